mc_ctrl_hs: RTL and testbench
=============================

Name: mc_ctrl_hs

Overview:
- Multicycle MIPS-subset main controller; successor of the fixed-latency 5-state controller.
- Adds a memory ready handshake, so fetch and data accesses may take any number of cycles.
- Adds a parametrised memory timeout, an illegal-opcode trap, an optional bne instruction, and a retired-instruction counter.
- Sits between the IR output and the datapath muxes, register file, PC and data memory.

Parameters:
TIMEOUT, 15, max wait cycles for mem_ready in a waiting state; 0 disables timeout
EXT_OPS, 1, 1 enables bne (opcode 000101); 0 decodes it as illegal
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
instr  in  32  IR contents; opcode [31:26], func [5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request active
regdst  out  2  00 rd, 01 rt, 10 r31
memwr  out  1  data memory write strobe
write_sel  out  2  00 ALU, 01 mem, 11 slt, 10 PC+4
pc_sel  out  2  00 PC+4, 01 branch, 10 jump, 11 jr
aluctr  out  2  00 add, 01 sub, 10 or
alusrc  out  1  ALU B from immediate
extop  out  2  00 zero-ext, 01 sign-ext, 10 lui shift
addi_ovf  out  1  instr is addi (overflow check enable)
en  out  1  register file write enable
pcwr  out  1  PC write
irwr  out  1  IR write
lb_op  out  1  instr is lb
sb_op  out  1  instr is sb
state  out  3  current state
illegal  out  1  sticky: illegal opcode/func trapped
timeout  out  1  sticky: memory timeout trapped
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: synchronous, active-high, overrides all other events, including mid-wait. Effects: state=FETCH, wait counter=0, illegal=0, timeout=0, retired=0.
- Decoded instructions:
  - lw 100011, sw 101011, lb 100000, sb 101000, ori 001101, beq 000100, lui 001111, j 000010, addi 001000, addiu 001001, jal 000011, bne 000101 (EXT_OPS=1 only).
  - R-type opcode 000000: addu 100001, subu 100011, slt 101010, jr 001000.
  - Anything else is illegal.
- Decode outputs are purely combinational from instr and independent of state: regdst, write_sel, aluctr, alusrc, extop, addi_ovf, lb_op, sb_op.
  - regdst[0] = ori|lw|sw|beq|bne|lui|addi|addiu|lb|sb; regdst[1] = jal.
  - aluctr[0] = subu|slt|beq|bne; aluctr[1] = ori.
  - alusrc = ori|lw|sw|lb|sb|lui|addi|addiu.
  - extop[0] = addi|addiu|beq|bne|lw|sw|lb|sb; extop[1] = lui.
  - write_sel[0] = lw|lb|slt|sw|sb; write_sel[1] = jal|slt.
- pc_sel: [0] = jr|beq|bne, [1] = j|jal|jr; both bits forced 0 in FETCH.
- States (encoding): FETCH 0, DECODE 1, MEMADDR 2, EXEC 3, COMMIT 4, TRAP 5.
- FETCH: mem_req=1. If mem_ready: irwr=1, pcwr=1, next state DECODE. Otherwise hold in FETCH.
- DECODE: 1 cycle, no strobes.
  - ALU ops and stores -> EXEC.
  - beq, bne, j, jal, jr -> COMMIT.
  - lw, lb -> MEMADDR.
  - Illegal -> TRAP with illegal set.
- MEMADDR: mem_req=1. Hold until mem_ready, then -> EXEC.
- EXEC: 1 cycle -> COMMIT.
- COMMIT:
  - Stores: mem_req=1 and memwr=1, held until mem_ready. On mem_ready -> FETCH.
  - All other instructions: 1 cycle -> FETCH.
  - en=1 on the final COMMIT cycle for addu, subu, slt, ori, lui, addi, addiu, lw, lb, jal.
  - pcwr=1 on the final COMMIT cycle for j, jal, jr, beq&zero, bne&~zero.
  - retired increments by 1 on the COMMIT->FETCH transition; wraps modulo 2^CNT_W.
- Wait counter:
  - Counts cycles spent in a state with mem_req=1 and mem_ready=0.
  - Clears on any state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT while mem_ready=0: -> TRAP, timeout=1. No strobe is issued that cycle.
  - mem_ready in the same cycle as counter==TIMEOUT: ready wins, normal transition.
  - TIMEOUT=0: wait forever.
- TRAP: all strobes 0 (mem_req, memwr, en, pcwr, irwr). Hold until rst; flags stay sticky.
- Only one of irwr or memwr is ever asserted per cycle. en and memwr are never asserted outside COMMIT.

Test Plan:
- Reset, then addu with mem_ready held 1 -> states 0,1,3,4,0; en=1 only in the state-4 cycle; retired=1 after 5 cycles.
- lw with mem_ready low 3 cycles in MEMADDR, TIMEOUT=15 -> MEMADDR held 4 cycles; write_sel=01, en=1 in COMMIT; no timeout.
- sw with mem_ready low 15 cycles in COMMIT -> state=5, timeout=1, memwr drops to 0; with mem_ready on the 15th wait cycle instead -> normal commit.
- beq zero=1 then zero=0; bne (EXT_OPS=1) zero=0 -> pcwr in COMMIT respectively 1, 0, 1; pc_sel=01. With EXT_OPS=0, bne -> TRAP, illegal=1.
- Opcode 111111 -> DECODE->TRAP, illegal=1. Sticky across 10 cycles; cleared only by rst=1 for 1 cycle, which returns state to 0 and sets retired=0.
- rst asserted mid-FETCH wait and mid-store COMMIT -> next cycle state=0, memwr=0, en=0; CNT_W=4 with 17 retired instructions -> retired=1.

Source files
------------

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS-subset main controller with a memory ready handshake, a
// wait-cycle timeout, an illegal-opcode trap and a retired-instruction counter.
module mc_ctrl_hs #(
    parameter int unsigned TIMEOUT = 15,
    parameter bit          EXT_OPS = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic [1:0]       regdst,
    output logic             memwr,
    output logic [1:0]       write_sel,
    output logic [1:0]       pc_sel,
    output logic [1:0]       aluctr,
    output logic             alusrc,
    output logic [1:0]       extop,
    output logic             addi_ovf,
    output logic             en,
    output logic             pcwr,
    output logic             irwr,
    output logic             lb_op,
    output logic             sb_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        MEMADDR = 3'd2,
        EXEC    = 3'd3,
        COMMIT  = 3'd4,
        TRAP    = 3'd5
    } state_t;

    // The counter only has to hold 0..TIMEOUT-1: the trap fires as it would reach TIMEOUT.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [5:0] op;
    logic [5:0] fn;
    logic       r_type;
    logic       is_addu, is_subu, is_slt, is_jr;
    logic       is_lw, is_sw, is_lb, is_sb, is_ori, is_beq, is_bne;
    logic       is_lui, is_j, is_jal, is_addi, is_addiu;
    logic       is_load, is_store, is_alu, is_ctrl, wr_reg, take_pc;
    logic       unused_instr_bits;

    assign op       = instr[31:26];
    assign fn       = instr[5:0];
    assign r_type   = (op == 6'b000000);
    assign is_addu  = r_type && (fn == 6'b100001);
    assign is_subu  = r_type && (fn == 6'b100011);
    assign is_slt   = r_type && (fn == 6'b101010);
    assign is_jr    = r_type && (fn == 6'b001000);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_lb    = (op == 6'b100000);
    assign is_sb    = (op == 6'b101000);
    assign is_ori   = (op == 6'b001101);
    assign is_beq   = (op == 6'b000100);
    assign is_bne   = EXT_OPS && (op == 6'b000101);
    assign is_lui   = (op == 6'b001111);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);
    assign is_addi  = (op == 6'b001000);
    assign is_addiu = (op == 6'b001001);
    assign unused_instr_bits = ^instr[25:6];

    assign is_load  = is_lw | is_lb;
    assign is_store = is_sw | is_sb;
    assign is_alu   = is_addu | is_subu | is_slt | is_ori | is_lui | is_addi | is_addiu;
    assign is_ctrl  = is_beq | is_bne | is_j | is_jal | is_jr;
    assign wr_reg   = is_alu | is_load | is_jal;
    assign take_pc  = is_j | is_jal | is_jr | (is_beq & zero) | (is_bne & ~zero);

    assign regdst    = {is_jal, is_ori | is_lw | is_sw | is_beq | is_bne | is_lui |
                                is_addi | is_addiu | is_lb | is_sb};
    assign aluctr    = {is_ori, is_subu | is_slt | is_beq | is_bne};
    assign alusrc    = is_ori | is_lw | is_sw | is_lb | is_sb | is_lui | is_addi | is_addiu;
    assign extop     = {is_lui, is_addi | is_addiu | is_beq | is_bne | is_lw | is_sw | is_lb | is_sb};
    assign write_sel = {is_jal | is_slt, is_lw | is_lb | is_slt | is_sw | is_sb};
    assign addi_ovf  = is_addi;
    assign lb_op     = is_lb;
    assign sb_op     = is_sb;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               wait_hit;

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;
    assign pc_sel  = (state_q == FETCH) ? 2'b00
                                        : {is_j | is_jal | is_jr, is_jr | is_beq | is_bne};
    // Only meaningful in states that are waiting on memory.
    assign wait_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST) && !mem_ready;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        retired_d = retired_q;
        mem_req   = 1'b0;
        memwr     = 1'b0;
        en        = 1'b0;
        pcwr      = 1'b0;
        irwr      = 1'b0;
        case (state_q)
            FETCH: begin
                if (wait_hit) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        irwr    = 1'b1;
                        pcwr    = 1'b1;
                        state_d = DECODE;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            DECODE: begin
                if (is_alu || is_store) state_d = EXEC;
                else if (is_ctrl)       state_d = COMMIT;
                else if (is_load)       state_d = MEMADDR;
                else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            MEMADDR: begin
                if (wait_hit) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) state_d = EXEC;
                    else           wait_d  = wait_q + 1'b1;
                end
            end
            EXEC: state_d = COMMIT;
            COMMIT: begin
                if (is_store) begin
                    if (wait_hit) begin
                        state_d   = TRAP;
                        timeout_d = 1'b1;
                    end else begin
                        mem_req = 1'b1;
                        memwr   = 1'b1;
                        if (mem_ready) begin
                            state_d   = FETCH;
                            retired_d = retired_q + 1'b1;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end else begin
                    en        = wr_reg;
                    pcwr      = take_pc;
                    state_d   = FETCH;
                    retired_d = retired_q + 1'b1;
                end
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
        if (state_d != state_q) wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Self-checking bench for mc_ctrl_hs: decode vector table, directed corner
// sequences and random instruction streams against an instruction-level model.
module tb_mc_ctrl_hs;
    localparam int TO = 15;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEMADDR = 3'd2,
                           S_EXEC = 3'd3, S_COMMIT = 3'd4, S_TRAP = 3'd5;
    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_CTRL = 3, C_ILL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, memwr, alusrc, addi_ovf, en, pcwr, irwr, lb_op, sb_op, illegal, timeout;
    logic [1:0]  regdst, write_sel, pc_sel, aluctr, extop;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        unused_alt_mem_req, unused_alt_memwr, unused_alt_alusrc, unused_alt_addi_ovf;
    logic        unused_alt_en, unused_alt_pcwr, unused_alt_irwr, unused_alt_lb_op;
    logic        unused_alt_sb_op, unused_alt_timeout;
    logic [1:0]  alt_regdst, unused_alt_write_sel, unused_alt_pc_sel, alt_aluctr, alt_extop;
    logic [2:0]  alt_state;
    logic        alt_illegal;
    logic [3:0]  alt_retired;

    always #5 clk = ~clk;

    mc_ctrl_hs #(.TIMEOUT(TO), .EXT_OPS(1'b1), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .regdst(regdst), .memwr(memwr), .write_sel(write_sel),
        .pc_sel(pc_sel), .aluctr(aluctr), .alusrc(alusrc), .extop(extop),
        .addi_ovf(addi_ovf), .en(en), .pcwr(pcwr), .irwr(irwr), .lb_op(lb_op),
        .sb_op(sb_op), .state(state), .illegal(illegal), .timeout(timeout),
        .retired(retired)
    );

    mc_ctrl_hs #(.TIMEOUT(TO), .EXT_OPS(1'b0), .CNT_W(4)) u_alt (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(unused_alt_mem_req), .regdst(alt_regdst), .memwr(unused_alt_memwr),
        .write_sel(unused_alt_write_sel), .pc_sel(unused_alt_pc_sel), .aluctr(alt_aluctr),
        .alusrc(unused_alt_alusrc), .extop(alt_extop), .addi_ovf(unused_alt_addi_ovf),
        .en(unused_alt_en), .pcwr(unused_alt_pcwr), .irwr(unused_alt_irwr),
        .lb_op(unused_alt_lb_op), .sb_op(unused_alt_sb_op), .state(alt_state),
        .illegal(alt_illegal), .timeout(unused_alt_timeout), .retired(alt_retired)
    );

    int errors = 0;
    int checks = 0;

    // Instruction-level model state
    logic [31:0] cur_instr = 32'h0;
    logic        cur_zero = 1'b0;
    int          retired_m = 0;
    bit          exp_ill = 1'b0;
    bit          exp_to = 1'b0;

    typedef struct {
        string      nm;
        logic [5:0] op;
        logic [5:0] fn;
        bit         rtype;
        int         cls;
        bit         wr;
        bit         jmp;
        int         br;      // 0 none, 1 taken on zero, 2 taken on not-zero
        logic [1:0] ps;
    } kind_t;
    kind_t kinds[18];

    typedef struct packed {
        logic [31:0] ins;
        logic [11:0] dec;    // regdst, write_sel, aluctr, alusrc, extop, addi_ovf, lb_op, sb_op
    } dec_vec_t;
    dec_vec_t dvec[18];
    string    dname[18];

    function automatic kind_t mk_kind(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                      input bit rt, input int cls, input bit wr, input bit jmp,
                                      input int br, input logic [1:0] ps);
        kind_t k;
        k.nm = nm; k.op = op; k.fn = fn; k.rtype = rt; k.cls = cls;
        k.wr = wr; k.jmp = jmp; k.br = br; k.ps = ps;
        return k;
    endfunction

    function automatic dec_vec_t mk_dec(input logic [5:0] op, input logic [5:0] fn,
                                        input logic [1:0] rd, input logic [1:0] ws,
                                        input logic [1:0] alu, input logic src,
                                        input logic [1:0] ext, input logic ovf,
                                        input logic lb, input logic sb);
        dec_vec_t v;
        v.ins = {op, 20'($urandom), fn};
        v.dec = {rd, ws, alu, src, ext, ovf, lb, sb};
        return v;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare cycle outputs.
    task automatic cyc(input logic [2:0] st, input logic rdy, input logic [4:0] strb,
                       input logic [1:0] ps, input string nm);
        logic [9:0] got;
        logic [9:0] exp;
        @(negedge clk);
        instr     = cur_instr;
        zero      = cur_zero;
        mem_ready = rdy;
        #1;
        got = {state, mem_req, memwr, en, pcwr, irwr, pc_sel};
        exp = {st, strb, ps};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d req/wr/en/pcwr/irwr=%b pc_sel=%b, expected state=%0d strobes=%b pc_sel=%b",
                     nm, got[9:7], got[6:2], got[1:0], st, strb, ps);
        end
    endtask

    // A memory wait: dly cycles of not-ready, then one ready cycle, unless
    // the wait reaches the timeout limit first.
    task automatic wait_phase(input logic [2:0] st, input int dly, input logic [4:0] ws,
                              input logic [4:0] ds, input logic [1:0] ps, input string nm,
                              output bit trapped);
        trapped = 1'b0;
        for (int w = 0; w < dly; w++) begin
            if (w == TO - 1) begin
                cyc(st, 1'b0, 5'b00000, ps, {nm, "_timeout"});
                trapped = 1'b1;
                return;
            end
            cyc(st, 1'b0, ws, ps, {nm, "_wait"});
        end
        cyc(st, 1'b1, ds, ps, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        retired_m = 0;
        exp_ill = 1'b0;
        exp_to = 1'b0;
        chk("rst_state", 64'(state), 64'(S_FETCH));
        chk("rst_retired", 64'(retired), 64'd0);
        chk("rst_flags", 64'({illegal, timeout}), 64'd0);
        chk("rst_memwr_en", 64'({memwr, en}), 64'd0);
        chk("rst_alt_state", 64'(alt_state), 64'(S_FETCH));
    endtask

    task automatic run_instr(input int k, input logic z, input int df, input int dm,
                             input int ds, input int tail);
        kind_t kd;
        bit    tr;
        bit    dead;
        bit    take;
        kd = kinds[k];
        cur_instr = {kd.op, 20'($urandom), kd.rtype ? kd.fn : 6'($urandom)};
        cur_zero  = z;
        take = kd.jmp || (kd.br == 1 && z) || (kd.br == 2 && !z);
        dead = 1'b0;
        wait_phase(S_FETCH, df, 5'b10000, 5'b10011, 2'b00, "fetch", tr);
        if (tr) begin
            dead = 1'b1;
            exp_to = 1'b1;
        end else begin
            cyc(S_DECODE, 1'($urandom_range(0, 1)), 5'b00000, kd.ps, "decode");
            if (kd.cls == C_ILL) begin
                dead = 1'b1;
                exp_ill = 1'b1;
            end else if (kd.cls == C_LOAD) begin
                wait_phase(S_MEMADDR, dm, 5'b10000, 5'b10000, kd.ps, "memaddr", tr);
                if (tr) begin
                    dead = 1'b1;
                    exp_to = 1'b1;
                end
            end
            if (!dead && kd.cls != C_CTRL)
                cyc(S_EXEC, 1'($urandom_range(0, 1)), 5'b00000, kd.ps, "exec");
        end
        if (!dead) begin
            if (kd.cls == C_STORE) begin
                wait_phase(S_COMMIT, ds, 5'b11000, 5'b11000, kd.ps, "commit_st", tr);
                if (tr) begin
                    dead = 1'b1;
                    exp_to = 1'b1;
                end
            end else begin
                cyc(S_COMMIT, 1'($urandom_range(0, 1)), {2'b00, kd.wr, take, 1'b0}, kd.ps, "commit");
            end
            if (!dead) retired_m++;
        end
        if (dead) begin
            for (int i = 0; i < tail; i++)
                cyc(S_TRAP, 1'($urandom_range(0, 1)), 5'b00000, kd.ps, "trap_hold");
        end
        @(posedge clk);
        #1;
        chk("retired", 64'(retired), 64'(retired_m));
        chk("illegal_flag", 64'(illegal), 64'(exp_ill));
        chk("timeout_flag", 64'(timeout), 64'(exp_to));
        $display("instr %-6s ins=%h zero=%0d df=%0d dm=%0d ds=%0d -> %s retired=%0d",
                 kd.nm, cur_instr, z, df, dm, ds, dead ? "trap" : "done", retired);
    endtask

    function automatic int pick_delay();
        case ($urandom_range(0, 15))
            0, 1, 2, 3, 4, 5: return 0;
            6, 7:             return 1;
            8, 9:             return 2;
            10, 11:           return 3;
            12:               return 5;
            13:               return TO - 1;
            14:               return TO;
            default:          return TO + 2;
        endcase
    endfunction

    initial begin
        kinds[0]  = mk_kind("addu",  6'h00, 6'h21, 1, C_ALU,   1, 0, 0, 2'b00);
        kinds[1]  = mk_kind("subu",  6'h00, 6'h23, 1, C_ALU,   1, 0, 0, 2'b00);
        kinds[2]  = mk_kind("slt",   6'h00, 6'h2A, 1, C_ALU,   1, 0, 0, 2'b00);
        kinds[3]  = mk_kind("jr",    6'h00, 6'h08, 1, C_CTRL,  0, 1, 0, 2'b11);
        kinds[4]  = mk_kind("lw",    6'h23, 6'h00, 0, C_LOAD,  1, 0, 0, 2'b00);
        kinds[5]  = mk_kind("lb",    6'h20, 6'h00, 0, C_LOAD,  1, 0, 0, 2'b00);
        kinds[6]  = mk_kind("sw",    6'h2B, 6'h00, 0, C_STORE, 0, 0, 0, 2'b00);
        kinds[7]  = mk_kind("sb",    6'h28, 6'h00, 0, C_STORE, 0, 0, 0, 2'b00);
        kinds[8]  = mk_kind("ori",   6'h0D, 6'h00, 0, C_ALU,   1, 0, 0, 2'b00);
        kinds[9]  = mk_kind("lui",   6'h0F, 6'h00, 0, C_ALU,   1, 0, 0, 2'b00);
        kinds[10] = mk_kind("addi",  6'h08, 6'h00, 0, C_ALU,   1, 0, 0, 2'b00);
        kinds[11] = mk_kind("addiu", 6'h09, 6'h00, 0, C_ALU,   1, 0, 0, 2'b00);
        kinds[12] = mk_kind("beq",   6'h04, 6'h00, 0, C_CTRL,  0, 0, 1, 2'b01);
        kinds[13] = mk_kind("bne",   6'h05, 6'h00, 0, C_CTRL,  0, 0, 2, 2'b01);
        kinds[14] = mk_kind("j",     6'h02, 6'h00, 0, C_CTRL,  0, 1, 0, 2'b10);
        kinds[15] = mk_kind("jal",   6'h03, 6'h00, 0, C_CTRL,  1, 1, 0, 2'b10);
        kinds[16] = mk_kind("ill3f", 6'h3F, 6'h00, 0, C_ILL,   0, 0, 0, 2'b00);
        kinds[17] = mk_kind("illR",  6'h00, 6'h20, 1, C_ILL,   0, 0, 0, 2'b00);

        //                    op     fn     regdst wsel   aluctr src ext   ovf lb sb
        dvec[0]  = mk_dec(6'h00, 6'h21, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0); dname[0]  = "dec_addu";
        dvec[1]  = mk_dec(6'h00, 6'h23, 2'b00, 2'b00, 2'b01, 0, 2'b00, 0, 0, 0); dname[1]  = "dec_subu";
        dvec[2]  = mk_dec(6'h00, 6'h2A, 2'b00, 2'b11, 2'b01, 0, 2'b00, 0, 0, 0); dname[2]  = "dec_slt";
        dvec[3]  = mk_dec(6'h00, 6'h08, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0); dname[3]  = "dec_jr";
        dvec[4]  = mk_dec(6'h00, 6'h20, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0); dname[4]  = "dec_illR";
        dvec[5]  = mk_dec(6'h23, 6'h21, 2'b01, 2'b01, 2'b00, 1, 2'b01, 0, 0, 0); dname[5]  = "dec_lw";
        dvec[6]  = mk_dec(6'h2B, 6'h2A, 2'b01, 2'b01, 2'b00, 1, 2'b01, 0, 0, 0); dname[6]  = "dec_sw";
        dvec[7]  = mk_dec(6'h20, 6'h2A, 2'b01, 2'b01, 2'b00, 1, 2'b01, 0, 1, 0); dname[7]  = "dec_lb";
        dvec[8]  = mk_dec(6'h28, 6'h08, 2'b01, 2'b01, 2'b00, 1, 2'b01, 0, 0, 1); dname[8]  = "dec_sb";
        dvec[9]  = mk_dec(6'h0D, 6'h23, 2'b01, 2'b00, 2'b10, 1, 2'b00, 0, 0, 0); dname[9]  = "dec_ori";
        dvec[10] = mk_dec(6'h04, 6'h00, 2'b01, 2'b00, 2'b01, 0, 2'b01, 0, 0, 0); dname[10] = "dec_beq";
        dvec[11] = mk_dec(6'h05, 6'h00, 2'b01, 2'b00, 2'b01, 0, 2'b01, 0, 0, 0); dname[11] = "dec_bne";
        dvec[12] = mk_dec(6'h0F, 6'h00, 2'b01, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0); dname[12] = "dec_lui";
        dvec[13] = mk_dec(6'h02, 6'h21, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0); dname[13] = "dec_j";
        dvec[14] = mk_dec(6'h03, 6'h00, 2'b10, 2'b10, 2'b00, 0, 2'b00, 0, 0, 0); dname[14] = "dec_jal";
        dvec[15] = mk_dec(6'h08, 6'h00, 2'b01, 2'b00, 2'b00, 1, 2'b01, 1, 0, 0); dname[15] = "dec_addi";
        dvec[16] = mk_dec(6'h09, 6'h00, 2'b01, 2'b00, 2'b00, 1, 2'b01, 0, 0, 0); dname[16] = "dec_addiu";
        dvec[17] = mk_dec(6'h3F, 6'h2A, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0); dname[17] = "dec_ill3f";

        // Decode table, applied while reset holds the FSM in FETCH.
        for (int i = 0; i < 18; i++) begin
            instr = dvec[i].ins;
            #1;
            chk(dname[i], 64'({regdst, write_sel, aluctr, alusrc, extop, addi_ovf, lb_op, sb_op}),
                64'(dvec[i].dec));
        end
        instr = {6'h00, 20'h0, 6'h08};
        #1;
        chk("pc_sel_forced_in_fetch", 64'(pc_sel), 64'd0);
        instr = {6'h05, 26'h0};
        #1;
        chk("alt_bne_not_decoded", 64'({alt_regdst, alt_aluctr, alt_extop}), 64'd0);

        do_reset();
        run_instr(0, 1'b0, 0, 0, 0, 0);               // addu, memory always ready
        run_instr(4, 1'b0, 0, 3, 0, 0);               // lw, 3 wait cycles in MEMADDR
        run_instr(6, 1'b0, 0, 0, TO, 3);              // sw never ready: timeout trap
        do_reset();
        run_instr(6, 1'b0, 0, 0, TO - 1, 0);          // sw ready on the last allowed cycle
        run_instr(12, 1'b1, 0, 0, 0, 0);              // beq taken
        run_instr(12, 1'b0, 0, 0, 0, 0);              // beq not taken
        run_instr(13, 1'b0, 0, 0, 0, 0);              // bne taken
        chk("alt_bne_trap_state", 64'(alt_state), 64'(S_TRAP));
        chk("alt_bne_illegal", 64'(alt_illegal), 64'd1);
        do_reset();
        run_instr(0, 1'b0, 1, 0, 0, 0);
        run_instr(16, 1'b0, 0, 0, 0, 10);             // illegal opcode, sticky for 10 cycles
        do_reset();

        // Reset in the middle of a fetch wait, then the wait counter must start fresh.
        cur_instr = {6'h00, 20'h0, 6'h21};
        for (int i = 0; i < 5; i++) cyc(S_FETCH, 1'b0, 5'b10000, 2'b00, "fetch_wait_pre_rst");
        do_reset();
        run_instr(0, 1'b0, TO - 1, 0, 0, 0);

        // Reset in the middle of a store commit wait.
        cur_instr = {6'h2B, 26'h0};
        cyc(S_FETCH, 1'b1, 5'b10011, 2'b00, "st_fetch");
        cyc(S_DECODE, 1'b0, 5'b00000, 2'b00, "st_decode");
        cyc(S_EXEC, 1'b0, 5'b00000, 2'b00, "st_exec");
        cyc(S_COMMIT, 1'b0, 5'b11000, 2'b00, "st_commit_wait");
        cyc(S_COMMIT, 1'b0, 5'b11000, 2'b00, "st_commit_wait");
        do_reset();

        // 17 retirements: the 4-bit counter of the second instance wraps to 1.
        for (int i = 0; i < 17; i++) run_instr(0, 1'b0, 0, 0, 0, 0);
        chk("alt_retired_wrap", 64'(alt_retired), 64'd1);

        do_reset();
        for (int n = 0; n < 200; n++) begin
            int k;
            k = ($urandom_range(0, 19) == 0) ? int'($urandom_range(16, 17)) : int'($urandom_range(0, 15));
            run_instr(k, 1'($urandom_range(0, 1)), pick_delay(), pick_delay(), pick_delay(),
                      int'($urandom_range(0, 3)));
            if (exp_ill || exp_to) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
